// File: rtl/cordic_kernel_scheduler.sv
// cordic_kernel_scheduler
// Round-robin front end that shares one pipelined cordic_kernel between
// NUM_REQ sample sources. The granted I/Q sample is registered into the
// kernel inputs. The requester tag travels through a delay line matched to
// the kernel latency, and each result is returned on a tagged result bus.
// Optional build macro CORDIC_KERNEL_SCHED_CHECK_EN adds sticky orphan/lost
// result detection (sched_err, sched_err_code).
module cordic_kernel_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 16,
    parameter int THETA_WIDTH = 16,
    parameter int LATENCY     = 16,
    localparam int TAG_WIDTH  = $clog2(NUM_REQ),
    localparam int CNT_WIDTH  = $clog2(LATENCY + 3)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          arb_enable,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_q,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         ck_data_i,
    output logic [DATA_WIDTH-1:0]         ck_data_q,
    output logic                          ck_enable,
    input  logic [DATA_WIDTH-1:0]         ck_output_data_i,
    input  logic [DATA_WIDTH-1:0]         ck_output_data_q,
    input  logic [THETA_WIDTH-1:0]        ck_output_data_theta,
    input  logic                          ck_output_data_valid,
    output logic                          res_valid,
    output logic [TAG_WIDTH-1:0]          res_tag,
    output logic [DATA_WIDTH-1:0]         res_data_i,
    output logic [DATA_WIDTH-1:0]         res_data_q,
    output logic [THETA_WIDTH-1:0]        res_theta,
`ifdef CORDIC_KERNEL_SCHED_CHECK_EN
    output logic                          sched_err,
    output logic [1:0]                    sched_err_code,
`endif
    output logic                          busy,
    output logic [CNT_WIDTH-1:0]          in_flight
);

    logic [TAG_WIDTH-1:0]         rr_ptr;
    logic [TAG_WIDTH-1:0]         grant_idx;
    logic                         xfer;
    logic signed [DATA_WIDTH-1:0] slice_i [NUM_REQ];
    logic signed [DATA_WIDTH-1:0] slice_q [NUM_REQ];

    logic [TAG_WIDTH-1:0]                issue_tag_p0;
    logic [LATENCY-1:0]                  tag_vld_p1;
    logic [LATENCY-1:0][TAG_WIDTH-1:0]   tag_p1;
    logic                                tag_vld_out;
    logic [TAG_WIDTH-1:0]                tag_out;

    assign tag_vld_out = tag_vld_p1[LATENCY-1];
    assign tag_out     = tag_p1[LATENCY-1];

    // Unpack the per-requester sample slices
    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            slice_i[k] = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            slice_q[k] = req_data_q[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Round-robin search upward from rr_ptr, wrapping modulo NUM_REQ
    always_comb begin
        int                   idx;
        logic [TAG_WIDTH-1:0] idx_w;
        req_ready = '0;
        grant_idx = '0;
        xfer      = 1'b0;
        idx       = 0;
        idx_w     = '0;
        if (arb_enable) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                idx = int'(rr_ptr) + i;
                if (idx >= NUM_REQ) idx = idx - NUM_REQ;
                idx_w = TAG_WIDTH'(idx);
                if (!xfer && req_valid[idx_w]) begin
                    xfer      = 1'b1;
                    grant_idx = idx_w;
                end
            end
        end
        if (xfer) req_ready[grant_idx] = 1'b1;
    end

    // Pointer moves just past the requester that transferred
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (xfer) begin
            if (grant_idx == TAG_WIDTH'(NUM_REQ - 1)) rr_ptr <= '0;
            else                                      rr_ptr <= grant_idx + 1'b1;
        end
    end

    // ---- stage p0: issue register driving the kernel inputs ----
    // Kernel data holds its last value between transfers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ck_enable    <= 1'b0;
            ck_data_i    <= '0;
            ck_data_q    <= '0;
            issue_tag_p0 <= '0;
        end else begin
            ck_enable <= xfer;
            if (xfer) begin
                ck_data_i    <= slice_i[grant_idx];
                ck_data_q    <= slice_q[grant_idx];
                issue_tag_p0 <= grant_idx;
            end
        end
    end

    // ---- stage p1: tag delay line, last stage lines up with kernel output valid ----
    // Shift {valid, tag} through LATENCY stages
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_vld_p1 <= '0;
            tag_p1     <= '0;
        end else begin
            tag_vld_p1[0] <= ck_enable;
            tag_p1[0]     <= issue_tag_p0;
            for (int s = 1; s < LATENCY; s++) begin
                tag_vld_p1[s] <= tag_vld_p1[s-1];
                tag_p1[s]     <= tag_p1[s-1];
            end
        end
    end

    // ---- stage p2: result register ----
    // Capture kernel outputs with the aligned tag; hold while idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_valid  <= 1'b0;
            res_tag    <= '0;
            res_data_i <= '0;
            res_data_q <= '0;
            res_theta  <= '0;
        end else begin
            res_valid <= ck_output_data_valid;
            if (ck_output_data_valid) begin
                res_data_i <= ck_output_data_i;
                res_data_q <= ck_output_data_q;
                res_theta  <= ck_output_data_theta;
`ifdef CORDIC_KERNEL_SCHED_CHECK_EN
                res_tag    <= tag_vld_out ? tag_out : '0;
`else
                res_tag    <= tag_out;
`endif
            end
        end
    end

    // Outstanding-sample counter; a stray result never wraps it below zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_flight <= '0;
        end else begin
            if (xfer && !(res_valid && in_flight != '0))
                in_flight <= in_flight + 1'b1;
            else if (!xfer && res_valid && in_flight != '0)
                in_flight <= in_flight - 1'b1;
        end
    end

    assign busy = (in_flight != '0);

`ifdef CORDIC_KERNEL_SCHED_CHECK_EN
    logic [1:0] err_code;

    // Sticky: bit0 orphan result, bit1 lost result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_code <= 2'b00;
        end else begin
            err_code <= err_code | {tag_vld_out & ~ck_output_data_valid,
                                    ck_output_data_valid & ~tag_vld_out};
        end
    end

    assign sched_err_code = err_code;
    assign sched_err      = |err_code;
`endif

endmodule

// File: tb/tb_cordic_kernel_scheduler.sv
// Directed bench for cordic_kernel_scheduler with a behavioural kernel model
// (LATENCY register stages; out_i = in_i + 1, out_q = in_q - 1,
// theta = {in_i[7:0], in_q[7:0]}).
module tb_cordic_kernel_scheduler;

    localparam int NR  = 4;
    localparam int DW  = 16;
    localparam int TW  = 16;
    localparam int LAT = 16;
    localparam int RES_DELAY = LAT + 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              arb_enable = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR*DW-1:0]  req_data_i = '0;
    logic [NR*DW-1:0]  req_data_q = '0;
    logic [NR-1:0]     req_ready;
    logic [DW-1:0]     ck_data_i, ck_data_q;
    logic              ck_enable;
    logic [DW-1:0]     ck_output_data_i, ck_output_data_q;
    logic [TW-1:0]     ck_output_data_theta;
    logic              ck_output_data_valid;
    logic              res_valid;
    logic [1:0]        res_tag;
    logic [DW-1:0]     res_data_i, res_data_q;
    logic [TW-1:0]     res_theta;
    logic              busy;
    logic [4:0]        in_flight;
`ifdef CORDIC_KERNEL_SCHED_CHECK_EN
    logic              sched_err;
    logic [1:0]        sched_err_code;
`endif
    logic              inj = 1'b0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    cordic_kernel_scheduler #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .THETA_WIDTH(TW), .LATENCY(LAT)
    ) dut (
        .clk(clk), .reset(reset), .arb_enable(arb_enable),
        .req_valid(req_valid), .req_data_i(req_data_i), .req_data_q(req_data_q),
        .req_ready(req_ready),
        .ck_data_i(ck_data_i), .ck_data_q(ck_data_q), .ck_enable(ck_enable),
        .ck_output_data_i(ck_output_data_i), .ck_output_data_q(ck_output_data_q),
        .ck_output_data_theta(ck_output_data_theta),
        .ck_output_data_valid(ck_output_data_valid),
        .res_valid(res_valid), .res_tag(res_tag),
        .res_data_i(res_data_i), .res_data_q(res_data_q), .res_theta(res_theta),
`ifdef CORDIC_KERNEL_SCHED_CHECK_EN
        .sched_err(sched_err), .sched_err_code(sched_err_code),
`endif
        .busy(busy), .in_flight(in_flight)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Kernel model
    logic [LAT-1:0] km_v;
    logic [DW-1:0]  km_i [LAT];
    logic [DW-1:0]  km_q [LAT];
    logic [DW-1:0]  km_last_i, km_last_q;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            km_v <= '0;
        end else begin
            km_v[0] <= ck_enable;
            km_i[0] <= ck_data_i;
            km_q[0] <= ck_data_q;
            for (int s = 1; s < LAT; s++) begin
                km_v[s] <= km_v[s-1];
                km_i[s] <= km_i[s-1];
                km_q[s] <= km_q[s-1];
            end
        end
    end

    assign km_last_i            = km_i[LAT-1];
    assign km_last_q            = km_q[LAT-1];
    assign ck_output_data_i     = km_last_i + 16'd1;
    assign ck_output_data_q     = km_last_q - 16'd1;
    assign ck_output_data_theta = {km_last_i[7:0], km_last_q[7:0]};
    assign ck_output_data_valid = km_v[LAT-1] | inj;

    // Grant / result recorders
    int g_tag[$];
    int g_cyc[$];
    int r_tag[$];
    int r_cyc[$];
    int r_i[$];
    int max_if    = 0;
    int busy_fall = -1;
    logic busy_prev = 1'b0;

    function automatic int oh2idx(input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++) if (v[i]) return i;
        return -1;
    endfunction

    always @(negedge clk) begin
        total++;
        assert ($onehot0(req_ready)) else begin
            bad++;
            $error("FAIL ready_onehot observed=%b required=at most one bit", req_ready);
        end
        if (|(req_valid & req_ready)) begin
            g_tag.push_back(oh2idx(req_ready));
            g_cyc.push_back(cyc);
        end
        if (res_valid) begin
            r_tag.push_back(int'(res_tag));
            r_cyc.push_back(cyc);
            r_i.push_back(int'(res_data_i));
        end
        if (int'(in_flight) > max_if) max_if = int'(in_flight);
        if (busy_prev && !busy) busy_fall = cyc;
        busy_prev = busy;
    end

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        g_tag.delete(); g_cyc.delete();
        r_tag.delete(); r_cyc.delete(); r_i.delete();
        max_if = 0;
        busy_fall = -1;
    endtask

    int exp2[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int exp3[5] = '{1, 3, 1, 3, 1};
    int rc;

    initial begin
        for (int k = 0; k < NR; k++) begin
            req_data_i[k*DW +: DW] = DW'(100 * (k + 1));
            req_data_q[k*DW +: DW] = DW'(k + 1);
        end

        // Reset state
        repeat (3) step();
        chk("rst_ck_enable", ck_enable, 0);
        chk("rst_ck_data_i", ck_data_i, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data_i", res_data_i, 0);
        chk("rst_in_flight", in_flight, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        step();

        // Single transfer from requester 0, I=100 Q=0
        clear_logs();
        req_data_q[0 +: DW] = 16'd0;
        arb_enable = 1'b1;
        req_valid  = 4'b0001;
        #1;
        chk("t1_ready", req_ready, 4'b0001);
        step();
        req_valid = 4'b0000;
        chk("t1_ck_enable", ck_enable, 1);
        chk("t1_ck_data_i", ck_data_i, 100);
        chk("t1_in_flight1", in_flight, 1);
        chk("t1_busy1", busy, 1);
        step();
        chk("t1_ck_enable_low", ck_enable, 0);
        chk("t1_ck_data_hold", ck_data_i, 100);
        repeat (25) step();
        chk("t1_nres", r_tag.size(), 1);
        chk("t1_tag", r_tag[0], 0);
        chk("t1_latency", r_cyc[0] - g_cyc[0], RES_DELAY);
        chk("t1_res_i", res_data_i, 101);
        chk("t1_res_q", res_data_q, 16'hFFFF);
        chk("t1_res_theta", res_theta, 16'h6400);
        chk("t1_in_flight0", in_flight, 0);
        chk("t1_busy0", busy, 0);
        req_data_q[0 +: DW] = 16'd1;

        // All four valid for 8 cycles from rr_ptr=0
        reset = 1'b1;
        step();
        reset = 1'b0;
        clear_logs();
        req_valid = 4'b1111;
        repeat (8) step();
        req_valid = 4'b0000;
        repeat (25) step();
        chk("t2_ngrant", g_tag.size(), 8);
        chk("t2_nres", r_tag.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t2_grant%0d", i), g_tag[i], exp2[i]);
            chk($sformatf("t2_tag%0d", i), r_tag[i], exp2[i]);
            chk($sformatf("t2_lat%0d", i), r_cyc[i] - g_cyc[i], RES_DELAY);
            chk($sformatf("t2_res_i%0d", i), r_i[i], 100 * (exp2[i] + 1) + 1);
        end
        chk("t2_res_contig", r_cyc[7] - r_cyc[0], 7);
        chk("t2_max_in_flight", max_if, 8);

        // rr_ptr=2 via one grant to requester 1, then 4'b1010 held
        clear_logs();
        req_valid = 4'b0010;
        step();
        req_valid = 4'b1010;
        repeat (4) step();
        req_valid = 4'b0000;
        repeat (25) step();
        chk("t3_ngrant", g_tag.size(), 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t3_grant%0d", i), g_tag[i], exp3[i]);
            chk($sformatf("t3_tag%0d", i), r_tag[i], exp3[i]);
        end

        // Single requester back-to-back, arb_enable dropped after 3 grants
        clear_logs();
        req_valid = 4'b0001;
        repeat (3) step();
        arb_enable = 1'b0;
        #1;
        chk("t4_ready_off0", req_ready, 0);
        step();
        chk("t4_ready_off1", req_ready, 0);
        step();
        chk("t4_ready_off2", req_ready, 0);
        req_valid = 4'b0000;
        repeat (25) step();
        chk("t4_ngrant", g_tag.size(), 3);
        chk("t4_nres", r_tag.size(), 3);
        chk("t4_b2b", g_cyc[2] - g_cyc[0], 2);
        chk("t4_tag2", r_tag[2], 0);
        chk("t4_busy_fall", busy_fall, r_cyc[2] + 1);

        // Reset with six samples in flight
        clear_logs();
        arb_enable = 1'b1;
        req_valid  = 4'b1111;
        repeat (6) step();
        req_valid = 4'b0000;
        step();
        chk("t5_in_flight6", in_flight, 6);
        reset = 1'b1;
        #1;
        chk("t5_rst_in_flight", in_flight, 0);
        chk("t5_rst_ck_enable", ck_enable, 0);
        chk("t5_rst_busy", busy, 0);
        repeat (2) step();
        reset = 1'b0;
        rc = r_tag.size();
        repeat (25) step();
        chk("t5_no_res", r_tag.size(), 0);
        clear_logs();
        req_valid = 4'b1111;
        step();
        req_valid = 4'b0000;
        repeat (25) step();
        chk("t5_grant_ptr0", g_tag[0], 0);
        chk("t5_nres_after", r_tag.size(), 1);
        chk("t5_lat_after", r_cyc[0] - g_cyc[0], RES_DELAY);
        chk("t5_rc", rc, 0);

`ifdef CORDIC_KERNEL_SCHED_CHECK_EN
        // Orphan result while idle
        chk("t6_err_clear", sched_err, 0);
        inj = 1'b1;
        step();
        inj = 1'b0;
        chk("t6_orphan_valid", res_valid, 1);
        chk("t6_orphan_tag", res_tag, 0);
        chk("t6_sched_err", sched_err, 1);
        chk("t6_err_code", sched_err_code, 2'b01);
        repeat (3) step();
        chk("t6_err_held", sched_err_code, 2'b01);
        chk("t6_in_flight", in_flight, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cordic_kernel_scheduler.md
Name: cordic_kernel_scheduler

Overview:
- Shares one pipelined cordic_kernel between NUM_REQ requesters using round-robin arbitration with a valid/ready input handshake.
- Registers the granted I/Q sample into the kernel's data_i/data_q/enable inputs.
- Carries the requester tag through a delay line matched to the kernel latency, then returns the kernel result on a shared tagged result bus.
- Sits between the front-end sample sources and cordic_kernel in the CORDIC subsystem.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- DATA_WIDTH, 16, width of the I/Q samples and of the kernel I/Q outputs.
- THETA_WIDTH, 16, width of the kernel output_data_theta.
- LATENCY, 16, cycles from kernel enable high to output_data_valid high for that sample; must be at least 1.
- TAG_WIDTH is a derived localparam: $clog2(NUM_REQ).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- arb_enable  in  1  when low, no new grants; in-flight samples drain normally
- req_valid  in  NUM_REQ  per-requester sample valid
- req_data_i  in  NUM_REQ*DATA_WIDTH  packed I samples; requester k occupies slice k
- req_data_q  in  NUM_REQ*DATA_WIDTH  packed Q samples; requester k occupies slice k
- req_ready  out  NUM_REQ  one-hot grant; at most one bit high
- ck_data_i  out  DATA_WIDTH  to kernel data_i
- ck_data_q  out  DATA_WIDTH  to kernel data_q
- ck_enable  out  1  to kernel enable
- ck_output_data_i  in  DATA_WIDTH  from kernel output_data_i
- ck_output_data_q  in  DATA_WIDTH  from kernel output_data_q
- ck_output_data_theta  in  THETA_WIDTH  from kernel output_data_theta
- ck_output_data_valid  in  1  from kernel output_data_valid
- res_valid  out  1  result valid, one-cycle pulse per sample
- res_tag  out  TAG_WIDTH  index of the requester that owns this result
- res_data_i  out  DATA_WIDTH  result magnitude/I
- res_data_q  out  DATA_WIDTH  result Q
- res_theta  out  THETA_WIDTH  result angle
- busy  out  1  high while any sample is in flight
- in_flight  out  $clog2(LATENCY+3)  count of samples accepted but not yet returned

Behaviour:
- Reset values: all registered outputs are 0. This covers ck_*, res_*, busy and in_flight. The round-robin pointer resets to 0 and the tag delay line is cleared.
- Arbitration (combinational ready):
  - If arb_enable=1, grant the first k with req_valid[k]=1, searching upward from rr_ptr and wrapping modulo NUM_REQ.
  - req_ready is one-hot on that k. req_ready is all 0 if arb_enable=0 or no requester is valid.
  - A transfer occurs when req_valid[k] & req_ready[k].
- Pointer update: on a transfer from k, rr_ptr <= (k+1) mod NUM_REQ. With no transfer, rr_ptr holds.
- Issue path:
  - A transfer at edge t sets ck_enable=1 and ck_data_i/q = the granted slice for cycle t+1.
  - Otherwise ck_enable=0. ck_data holds its last value.
  - Throughput is one sample per cycle with no bubbles.
- Tag pipeline: shift register of LATENCY stages of {valid, tag}, loaded from the issue register. It is aligned so that stage output coincides with ck_output_data_valid.
- Result path:
  - When ck_output_data_valid=1, register the kernel outputs and the aligned tag.
  - res_valid=1 at t+2+LATENCY relative to the transfer edge t, for exactly one cycle.
  - res_* hold their values when res_valid=0.
- Result ordering: results return in issue order. The bus has no backpressure, so consumers must accept every res_valid pulse.
- in_flight:
  - Increments on a transfer and decrements on res_valid.
  - A simultaneous transfer and res_valid leaves it unchanged.
  - busy = (in_flight != 0).
- arb_enable falling mid-stream: stops grants from the next evaluation. Outstanding samples still complete, and busy falls one cycle after the last res_valid.
- Asynchronous reset mid-operation: discards all in-flight tags and results, and no res_valid is produced for them. The kernel is reset by the same reset.
- Single requester active: it is granted every cycle (back-to-back). The pointer still advances to k+1 and wraps back to it.

Optional Feature:
- Macro: CORDIC_KERNEL_SCHED_CHECK_EN.
- With the macro defined:
  - Adds output port sched_err (1 bit) and sticky register err_code (2 bits), reported on sched_err_code (out, 2 bits).
  - Bit0 sets when ck_output_data_valid=1 with no valid tag at the delay-line output (orphan result).
  - Bit1 sets when a valid tag reaches the delay-line output without ck_output_data_valid (lost result).
  - sched_err = |err_code. Both are cleared only by reset.
  - An orphan result is still presented on res_* with res_tag=0.
- Without the macro: these ports and the logic are absent. The result path is qualified by ck_output_data_valid alone.

Test Plan:
- Reset, then req_valid=4'b0001 with I=100, Q=0 for one cycle -> ck_enable pulses once at t+1; res_valid pulses once at t+18 with res_tag=0; in_flight goes 0->1->0.
- All four requesters valid continuously for 8 cycles from rr_ptr=0 -> grants in order 0,1,2,3,0,1,2,3; res_tag follows the same order on 8 consecutive res_valid cycles; in_flight peaks at 8 or fewer.
- req_valid=4'b1010 held, rr_ptr=2 -> grant order 3,1,3,1; requesters 0 and 2 are never granted.
- Stream 5 samples, drop arb_enable after the 3rd grant -> exactly 3 res_valid pulses; req_ready stays 0 while arb_enable=0; busy falls one cycle after the 3rd result.
- Assert reset for 2 cycles while in_flight=6 -> no res_valid during or after reset; in_flight=0, rr_ptr=0; a new single transfer after reset returns normally.
- With CORDIC_KERNEL_SCHED_CHECK_EN, force ck_output_data_valid=1 for one cycle while idle -> sched_err=1, err_code=2'b01, held until reset.
